// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 receiver for the SoC uart_tx pad.
// Bytes land in a first-word-fall-through FIFO with a valid/ready read port.
module uart_rx_monitor #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 clr_i,
  input  logic                 rx_i,
  output logic [7:0]           rdata_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [DIV_WIDTH-1:0] T_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] T_MIN  = DIV_WIDTH'(4);
  localparam logic [AW-1:0]        P_ONE  = AW'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_FULL = CNT_WIDTH'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // synchronizer and edge-detect state
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  // receiver state
  state_e               state_q;
  logic [DIV_WIDTH-1:0] timer_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [2:0]           bit_q;
  logic [7:0]           shift_q;
  logic                 frame_err_q;

  // fifo state
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q;
  logic [AW-1:0]        wptr_d;
  logic [AW-1:0]        rptr_q;
  logic [AW-1:0]        rptr_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 ovf_q;
  logic                 ovf_d;

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 fall;
  logic                 tick;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 do_push;

  // Clamp tiny divisors so the half-bit start delay stays meaningful.
  assign div_eff = (cfg_div_i < T_MIN) ? T_MIN : cfg_div_i;
  assign fall    = rx_prev_q & ~rx_s_q;
  assign tick    = (timer_q == '0);

  // Stop bit sampled high: the assembled byte is handed to the FIFO.
  assign push = (state_q == S_STOP) & tick & rx_s_q & ~clr_i;
  assign pop  = rvalid_o & rready_i & ~clr_i;
  assign full = (count_q == C_FULL);

  // A push into a full FIFO is only legal if the head leaves the same cycle.
  assign do_push = push & (~full | pop);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Receive FSM: mid-bit sampling with a down-counting bit timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      div_q       <= T_MIN;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else if (clr_i) begin
      // Abort; a low line waits for idle so no data bit looks like a start.
      state_q     <= rx_s_q ? S_IDLE : S_BREAK;
      timer_q     <= '0;
      bit_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fall) begin
            div_q   <= div_eff;
            timer_q <= (div_eff >> 1) - T_ONE;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (!rx_s_q) begin
              timer_q <= div_q - T_ONE;
              bit_q   <= '0;
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            timer_q <= div_q - T_ONE;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Next-state for FIFO pointers, fill level and overflow flag.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push && !do_push) begin
        ovf_d = 1'b1;
      end
      if (do_push) begin
        wptr_d = wptr_q + P_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + P_ONE;
      end
      unique case ({do_push, pop})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= shift_q;
    end
  end

  assign rvalid_o    = (count_q != '0);
  assign rdata_o     = rvalid_o ? mem_q[rptr_q] : 8'h00;
  assign count_o     = count_q;
  assign busy_o      = (state_q != S_IDLE);
  assign frame_err_o = frame_err_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed 8N1 frames against uart_rx_monitor.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_uart_rx_monitor;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] cfg_div_i;
  logic          clr_i;
  logic          rx_i;
  logic [7:0]    rdata_o;
  logic          rvalid_o;
  logic          rready_i;
  logic [CW-1:0] count_o;
  logic          busy_o;
  logic          frame_err_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;
  int lat;
  int bc;

  always #5 clk = ~clk;

  uart_rx_monitor #(
    .DIV_WIDTH (DW),
    .FIFO_DEPTH(8),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_div_i  (cfg_div_i),
    .clr_i      (clr_i),
    .rx_i       (rx_i),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .rready_i   (rready_i),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; the line is left at the stop-bit level.
  task automatic send(input logic [7:0] d,
                      input logic stopb,
                      input int div);
    rx_i = 1'b0;
    cyc(div);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      cyc(div);
    end
    rx_i = stopb;
    cyc(div);
  endtask

  task automatic pop1();
    rready_i = 1'b1;
    cyc(1);
    rready_i = 1'b0;
  endtask

  task automatic clear();
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_div_i = 16'd32;
    clr_i     = 1'b0;
    rx_i      = 1'b1;
    rready_i  = 1'b0;
    cyc(3);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_count",  32'(count_o),  32'd0);
    chk("rst_rdata",  32'(rdata_o),  32'd0);
    chk("rst_busy",   32'(busy_o),   32'd0);
    chk("rst_ferr",   32'(frame_err_o), 32'd0);
    chk("rst_ovf",    32'(overflow_o),  32'd0);
    rst = 1'b0;
    cyc(4);

    // single byte, latency 2 + 16 + 9*32 = 306 +/- 1
    fork
      send(8'h55, 1'b1, 32);
      begin
        lat = 0;
        while (!rvalid_o && lat < 400) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
      end
    join
    chk("t1_latency", 32'(lat >= 305 && lat <= 307), 32'd1);
    chk("t1_rdata", 32'(rdata_o), 32'h55);
    chk("t1_count", 32'(count_o), 32'd1);
    chk("t1_ferr",  32'(frame_err_o), 32'd0);
    chk("t1_ovf",   32'(overflow_o),  32'd0);
    chk("t1_busy",  32'(busy_o), 32'd0);
    pop1();
    chk("t1_pop_rvalid", 32'(rvalid_o), 32'd0);
    chk("t1_pop_rdata",  32'(rdata_o),  32'd0);

    // nine back-to-back frames into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      send(8'(i), 1'b1, 32);
    end
    cyc(4);
    chk("t2_count", 32'(count_o), 32'd8);
    chk("t2_ovf",   32'(overflow_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain", 32'(rdata_o), 32'(i));
      pop1();
    end
    chk("t2_empty", 32'(rvalid_o), 32'd0);
    chk("t2_ovf_sticky", 32'(overflow_o), 32'd1);
    clear();
    chk("t2_ovf_clr", 32'(overflow_o), 32'd0);

    // bad stop bit followed by a 40-bit break, then a good frame
    send(8'hA3, 1'b0, 32);
    cyc(40 * 32);
    chk("t3_ferr",   32'(frame_err_o), 32'd1);
    chk("t3_busy",   32'(busy_o), 32'd1);
    chk("t3_nobyte", 32'(rvalid_o), 32'd0);
    rx_i = 1'b1;
    cyc(64);
    chk("t3_idle", 32'(busy_o), 32'd0);
    send(8'h3C, 1'b1, 32);
    cyc(4);
    chk("t3_rdata", 32'(rdata_o), 32'h3C);
    chk("t3_count", 32'(count_o), 32'd1);
    chk("t3_ferr_sticky", 32'(frame_err_o), 32'd1);
    clear();
    chk("t3_ferr_clr", 32'(frame_err_o), 32'd0);
    chk("t3_count_clr", 32'(count_o), 32'd0);

    // 10-cycle glitch: START is entered and abandoned at mid-bit
    fork
      begin
        rx_i = 1'b0;
        cyc(10);
        rx_i = 1'b1;
      end
      begin
        bc = 0;
        repeat (40) begin
          cyc(1);
          if (busy_o) bc++;
        end
      end
    join
    chk("t4_busy_len", 32'(bc >= 15 && bc <= 17), 32'd1);
    chk("t4_busy", 32'(busy_o), 32'd0);
    chk("t4_count", 32'(count_o), 32'd0);
    chk("t4_ferr", 32'(frame_err_o), 32'd0);
    chk("t4_ovf", 32'(overflow_o), 32'd0);

    // full FIFO, pop coincides with the push edge (edge 307 after start)
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h10 + i), 1'b1, 32);
    end
    chk("t5_full", 32'(count_o), 32'd8);
    fork
      send(8'h99, 1'b1, 32);
      begin
        cyc(306);
        rready_i = 1'b1;
        cyc(1);
        rready_i = 1'b0;
      end
    join
    chk("t5_ovf", 32'(overflow_o), 32'd0);
    chk("t5_count", 32'(count_o), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t5_drain", 32'(rdata_o),
          (i < 7) ? 32'(8'h11 + i) : 32'h99);
      pop1();
    end
    chk("t5_empty", 32'(rvalid_o), 32'd0);

    // divisor 2 is clamped to 4
    cfg_div_i = 16'd2;
    send(8'hF0, 1'b1, 4);
    cyc(4);
    chk("t6_rdata", 32'(rdata_o), 32'hF0);
    chk("t6_count", 32'(count_o), 32'd1);

    // asynchronous reset in the middle of a frame
    fork
      send(8'hA5, 1'b1, 4);
      begin
        cyc(15);
        chk("t6_busy_pre", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("t6_rst_count",  32'(count_o),  32'd0);
        chk("t6_rst_rdata",  32'(rdata_o),  32'd0);
        chk("t6_rst_busy",   32'(busy_o),   32'd0);
      end
    join
    rst = 1'b0;
    cyc(5);
    send(8'h81, 1'b1, 4);
    cyc(4);
    chk("t6_rdata2", 32'(rdata_o), 32'h81);
    chk("t6_count2", 32'(count_o), 32'd1);
    chk("t6_ferr2",  32'(frame_err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
